// File: rtl/alien_formation_ctrl.sv
// alien_formation_ctrl
// Frame-synchronous motion controller for the three-alien formation.
// A frame tick is taken when the timing generator reaches the first
// non-visible row at column 0. The formation moves once every
// (speed+1) frames, drops and reverses at the screen edges, and stops
// when it reaches the ship row. All updates land in vertical blanking.
module alien_formation_ctrl #(
  parameter int V_ACTIVE = 480,
  parameter int X_MIN    = 0,
  parameter int X_MAX    = 640,
  parameter int FORM_W   = 80,
  parameter int PITCH    = 30,
  parameter int SPR_H    = 20,
  parameter int X_START  = 290,
  parameter int Y_START  = 40,
  parameter int STEP     = 4,
  parameter int DROP     = 10,
  parameter int LAND_Y   = 380
) (
  input  logic        vga_clk,
  input  logic        wb_rst_i,
  input  logic [11:0] pixel_row,
  input  logic [11:0] pixel_column,
  input  logic        cfg_wr,
  input  logic        cfg_enable,
  input  logic [3:0]  cfg_speed,
  input  logic        restart,
  output logic [9:0]  alien0_x,
  output logic [9:0]  alien1_x,
  output logic [9:0]  alien2_x,
  output logic [9:0]  alien_y,
  output logic        dir,
  output logic        landed,
  output logic        frame_pulse,
  output logic        move_pulse
);

  // 10-bit position constants and 11-bit compare constants. Edge tests are
  // done one bit wider so that x + FORM_W can never wrap.
  localparam logic [9:0]  LP_X_START = 10'(X_START);
  localparam logic [9:0]  LP_Y_START = 10'(Y_START);
  localparam logic [9:0]  LP_STEP    = 10'(STEP);
  localparam logic [9:0]  LP_DROP    = 10'(DROP);
  localparam logic [9:0]  LP_PITCH   = 10'(PITCH);
  localparam logic [9:0]  LP_PITCH2  = 10'(2 * PITCH);
  localparam logic [10:0] LP_STEP11  = 11'(STEP);
  localparam logic [10:0] LP_FORMW11 = 11'(FORM_W);
  localparam logic [10:0] LP_XMAX11  = 11'(X_MAX);
  localparam logic [10:0] LP_XMIN11  = 11'(X_MIN);
  localparam logic [10:0] LP_SPRH11  = 11'(SPR_H);
  localparam logic [10:0] LP_LANDY11 = 11'(LAND_Y);
  localparam logic [11:0] LP_VACT    = 12'(V_ACTIVE);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_LANDED = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic        r_enable;
  logic [3:0]  r_speed;
  logic [3:0]  r_frame_cnt;
  logic        r_match_d;
  logic        r_frame_pulse;
  logic [9:0]  r_x;
  logic [9:0]  r_x1;
  logic [9:0]  r_x2;
  logic [9:0]  r_y;
  logic        r_dir;
  logic        r_landed;
  logic        r_move_pulse;

  logic        w_match;
  logic        w_count_en;
  logic        w_move_due;
  logic [10:0] w_x11;
  logic        w_edge;
  logic [9:0]  w_y_drop;
  logic        w_drop_lands;
  logic        w_land_hit;
  logic [9:0]  w_x_nxt;
  logic [9:0]  w_y_nxt;
  logic        w_dir_nxt;
  logic [3:0]  w_cnt_nxt;
  logic        w_landed_nxt;
  logic        w_move_nxt;

  assign w_match = (pixel_row == LP_VACT) && (pixel_column == 12'd0);

  // Frame tick: rising edge of the (V_ACTIVE, 0) match, registered once.
  always_ff @(posedge vga_clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_match_d     <= 1'b0;
      r_frame_pulse <= 1'b0;
    end else begin
      r_match_d     <= w_match;
      r_frame_pulse <= w_match & ~r_match_d;
    end
  end

  // Configuration registers, loaded only on cfg_wr.
  always_ff @(posedge vga_clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_enable <= 1'b0;
      r_speed  <= 4'd0;
    end else if (cfg_wr) begin
      r_enable <= cfg_enable;
      r_speed  <= cfg_speed;
    end else begin
      r_enable <= r_enable;
      r_speed  <= r_speed;
    end
  end

  // Edge and landing arithmetic for the pending move.
  always_comb begin
    w_x11        = {1'b0, r_x};
    w_move_due   = (r_frame_cnt >= r_speed);
    w_y_drop     = r_y + LP_DROP;
    w_drop_lands = (({1'b0, w_y_drop} + LP_SPRH11) >= LP_LANDY11);
    if (r_dir) begin
      w_edge = ((w_x11 + LP_STEP11 + LP_FORMW11) > LP_XMAX11);
    end else begin
      w_edge = (w_x11 < (LP_XMIN11 + LP_STEP11));
    end
  end

  // FSM state register.
  always_ff @(posedge vga_clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state: restart overrides everything; landing ends the run.
  always_comb begin
    w_state_nxt = r_state;
    if (restart) begin
      w_state_nxt = r_enable ? S_RUN : S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   w_state_nxt = r_enable ? S_RUN : S_IDLE;
        S_RUN: begin
          if (w_land_hit) begin
            w_state_nxt = S_LANDED;
          end else if (!r_enable) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_RUN;
          end
        end
        S_LANDED: w_state_nxt = S_LANDED;
        default:  w_state_nxt = S_IDLE;
      endcase
    end
  end

  // FSM outputs: frames are counted only while running and enabled.
  always_comb begin
    w_count_en = (r_state == S_RUN) && r_enable && r_frame_pulse && !restart;
    w_land_hit = w_count_en && w_move_due && w_edge && w_drop_lands;
  end

  // Next position / counter values for this cycle.
  always_comb begin
    w_x_nxt      = r_x;
    w_y_nxt      = r_y;
    w_dir_nxt    = r_dir;
    w_cnt_nxt    = r_frame_cnt;
    w_landed_nxt = r_landed;
    w_move_nxt   = 1'b0;
    if (restart) begin
      w_x_nxt      = LP_X_START;
      w_y_nxt      = LP_Y_START;
      w_dir_nxt    = 1'b1;
      w_cnt_nxt    = 4'd0;
      w_landed_nxt = 1'b0;
    end else if (w_count_en) begin
      if (w_move_due) begin
        w_cnt_nxt  = 4'd0;
        w_move_nxt = 1'b1;
        if (w_edge) begin
          w_y_nxt      = w_y_drop;
          w_dir_nxt    = ~r_dir;
          w_landed_nxt = r_landed | w_drop_lands;
        end else if (r_dir) begin
          w_x_nxt = r_x + LP_STEP;
        end else begin
          w_x_nxt = r_x - LP_STEP;
        end
      end else begin
        w_cnt_nxt = r_frame_cnt + 4'd1;
      end
    end else begin
      w_move_nxt = 1'b0;
    end
  end

  // Position registers; sprite origins are registered alongside x.
  always_ff @(posedge vga_clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_x          <= LP_X_START;
      r_x1         <= LP_X_START + LP_PITCH;
      r_x2         <= LP_X_START + LP_PITCH2;
      r_y          <= LP_Y_START;
      r_dir        <= 1'b1;
      r_frame_cnt  <= 4'd0;
      r_landed     <= 1'b0;
      r_move_pulse <= 1'b0;
    end else begin
      r_x          <= w_x_nxt;
      r_x1         <= w_x_nxt + LP_PITCH;
      r_x2         <= w_x_nxt + LP_PITCH2;
      r_y          <= w_y_nxt;
      r_dir        <= w_dir_nxt;
      r_frame_cnt  <= w_cnt_nxt;
      r_landed     <= w_landed_nxt;
      r_move_pulse <= w_move_nxt;
    end
  end

  assign alien0_x    = r_x;
  assign alien1_x    = r_x1;
  assign alien2_x    = r_x2;
  assign alien_y     = r_y;
  assign dir         = r_dir;
  assign landed      = r_landed;
  assign frame_pulse = r_frame_pulse;
  assign move_pulse  = r_move_pulse;

endmodule

// File: tb/tb_alien_formation_ctrl.sv
// Testbench for alien_formation_ctrl: randomized timing-generator
// stimulus, a frame-level reference model, and a scoreboard whose
// monitor checks each frame's outcome when the DUT raises frame_pulse.
`timescale 1ns/1ps
module tb_alien_formation_ctrl;

  logic        vga_clk = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic [11:0] pixel_row = 12'd0;
  logic [11:0] pixel_column = 12'd0;
  logic        cfg_wr = 1'b0;
  logic        cfg_enable = 1'b0;
  logic [3:0]  cfg_speed = 4'd0;
  logic        restart = 1'b0;
  logic [9:0]  alien0_x, alien1_x, alien2_x, alien_y;
  logic        dir, landed, frame_pulse, move_pulse;

  always #5 vga_clk = ~vga_clk;

  alien_formation_ctrl dut (
    .vga_clk(vga_clk), .wb_rst_i(wb_rst_i),
    .pixel_row(pixel_row), .pixel_column(pixel_column),
    .cfg_wr(cfg_wr), .cfg_enable(cfg_enable), .cfg_speed(cfg_speed),
    .restart(restart),
    .alien0_x(alien0_x), .alien1_x(alien1_x), .alien2_x(alien2_x),
    .alien_y(alien_y), .dir(dir), .landed(landed),
    .frame_pulse(frame_pulse), .move_pulse(move_pulse)
  );

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int x; int y; int dir; int landed; int moved;
  } exp_t;
  exp_t sb_q[$];
  exp_t pexp;
  bit   pend = 1'b0;

  // Reference model state (mode: 0 idle, 1 run, 2 landed)
  int m_en, m_spd, m_mode, m_x, m_y, m_dir, m_cnt, m_land, m_fp, m_prev, m_mp;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_en = 0; m_spd = 0; m_mode = 0; m_x = 290; m_y = 40; m_dir = 1;
    m_cnt = 0; m_land = 0; m_fp = 0; m_prev = 0; m_mp = 0;
  endtask

  // One formation move following the screen-edge rules.
  task automatic model_move();
    int hit;
    if (m_dir == 1) hit = (m_x + 4 + 80 > 640);
    else            hit = (m_x < 0 + 4);
    if (hit != 0) begin
      m_y   = m_y + 10;
      m_dir = 1 - m_dir;
      if (m_y + 20 >= 380) begin
        m_land = 1;
        m_mode = 2;
      end
    end else begin
      m_x = (m_dir == 1) ? m_x + 4 : m_x - 4;
    end
  endtask

  // Advance the model by one clock given the inputs currently applied.
  task automatic model_step();
    int match, nfp, moved;
    match = (pixel_row == 12'd480 && pixel_column == 12'd0) ? 1 : 0;
    nfp   = (match == 1 && m_prev == 0) ? 1 : 0;
    moved = 0;
    if (restart) begin
      m_x = 290; m_y = 40; m_dir = 1; m_cnt = 0; m_land = 0;
      m_mode = (m_en != 0) ? 1 : 0;
    end else if (m_mode == 1 && m_en == 1 && m_fp == 1) begin
      if (m_cnt >= m_spd) begin
        moved = 1;
        m_cnt = 0;
        model_move();
      end else begin
        m_cnt = m_cnt + 1;
      end
    end else if (m_mode == 0 && m_en == 1) begin
      m_mode = 1;
    end else if (m_mode == 1 && m_en == 0) begin
      m_mode = 0;
    end
    if (m_fp == 1) sb_q.push_back('{m_x, m_y, m_dir, m_land, moved});
    if (cfg_wr) begin
      m_en  = int'(cfg_enable);
      m_spd = int'(cfg_speed);
    end
    m_prev = match;
    m_fp   = nfp;
    m_mp   = moved;
  endtask

  task automatic check_now();
    check("now_x0", int'(alien0_x), m_x);
    check("now_x1", int'(alien1_x), m_x + 30);
    check("now_x2", int'(alien2_x), m_x + 60);
    check("now_y", int'(alien_y), m_y);
    check("now_dir", int'(dir), m_dir);
    check("now_landed", int'(landed), m_land);
    check("now_frame_pulse", int'(frame_pulse), m_fp);
    check("now_move_pulse", int'(move_pulse), m_mp);
  endtask

  task automatic cyc(input int r, input int c, input int cw, input int ce,
                     input int cs, input int rs, input int chk);
    @(posedge vga_clk);
    #1;
    if (chk != 0) check_now();
    wb_rst_i     = 1'b0;
    pixel_row    = 12'(r);
    pixel_column = 12'(c);
    cfg_wr       = (cw != 0);
    cfg_enable   = (ce != 0);
    cfg_speed    = 4'(cs);
    restart      = (rs != 0);
    model_step();
  endtask

  task automatic noise(output int r, output int c);
    r = $urandom_range(0, 524);
    c = (r == 480) ? $urandom_range(1, 799) : $urandom_range(0, 799);
  endtask

  task automatic idle_cyc(input int cw, input int ce, input int cs, input int rs, input int chk);
    int r, c;
    noise(r, c);
    cyc(r, c, cw, ce, cs, rs, chk);
  endtask

  // One frame of len cycles; tick on cycle 0 (sometimes held into cycle 1).
  task automatic frame(input int len, input int rs_at, input int cw_at,
                       input int ce, input int cs);
    int r, c;
    bit hold;
    hold = (len >= 4) && ($urandom_range(0, 3) == 0);
    for (int i = 0; i < len; i++) begin
      if (i == 0 || (i == 1 && hold)) begin
        r = 480; c = 0;
      end else begin
        noise(r, c);
      end
      cyc(r, c, (i == cw_at) ? 1 : 0, ce, cs, (i == rs_at) ? 1 : 0, 0);
    end
  endtask

  // Monitor: pop the expected outcome on frame_pulse, compare next cycle.
  initial begin
    forever begin
      @(negedge vga_clk);
      if (wb_rst_i) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          check("sb_move_pulse", int'(move_pulse), pexp.moved);
          check("sb_x0", int'(alien0_x), pexp.x);
          check("sb_x1", int'(alien1_x), pexp.x + 30);
          check("sb_x2", int'(alien2_x), pexp.x + 60);
          check("sb_y", int'(alien_y), pexp.y);
          check("sb_dir", int'(dir), pexp.dir);
          check("sb_landed", int'(landed), pexp.landed);
          pend = 1'b0;
        end else if (move_pulse) begin
          check("stray_move_pulse", 1, 0);
        end
        if (frame_pulse) begin
          if (sb_q.size() == 0) begin
            check("unexpected_frame_pulse", 1, 0);
          end else begin
            pexp = sb_q.pop_front();
            pend = 1'b1;
          end
        end
      end
    end
  end

  // Watchdog on total run time.
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard, len, rs_at, cw_at, ce, cs, x_save;
    model_reset();
    repeat (3) @(posedge vga_clk);
    #1;
    check("reset_x0", int'(alien0_x), 290);
    check("reset_x1", int'(alien1_x), 320);
    check("reset_x2", int'(alien2_x), 350);
    check("reset_y", int'(alien_y), 40);
    check("reset_dir", int'(dir), 1);
    check("reset_landed", int'(landed), 0);
    check("reset_frame_pulse", int'(frame_pulse), 0);
    check("reset_move_pulse", int'(move_pulse), 0);

    // Enable at speed 0, five frames
    idle_cyc(1, 1, 0, 0, 0);
    idle_cyc(0, 1, 0, 0, 1);
    for (int f = 0; f < 5; f++) frame($urandom_range(3, 6), -1, -1, 1, 0);
    check("run5_x0", int'(alien0_x), 310);
    check("run5_x1", int'(alien1_x), 340);
    check("run5_x2", int'(alien2_x), 370);
    check("run5_y", int'(alien_y), 40);
    check("run5_dir", int'(dir), 1);

    // Speed 3: moves on frames 4 and 8
    idle_cyc(1, 1, 3, 0, 0);
    for (int f = 0; f < 8; f++) frame($urandom_range(3, 6), -1, -1, 1, 3);
    check("speed3_x0", int'(alien0_x), 318);

    // Disable at frame_cnt=2, then resume
    idle_cyc(0, 1, 3, 1, 0);
    idle_cyc(0, 1, 3, 0, 1);
    frame(4, -1, -1, 1, 3);
    frame(4, -1, -1, 1, 3);
    idle_cyc(1, 0, 3, 0, 0);
    for (int f = 0; f < 3; f++) frame(4, -1, -1, 0, 3);
    check("disabled_x0", int'(alien0_x), 290);
    idle_cyc(1, 1, 3, 0, 0);
    idle_cyc(0, 1, 3, 0, 0);
    frame(4, -1, -1, 1, 3);
    check("resume1_x0", int'(alien0_x), 290);
    frame(4, -1, -1, 1, 3);
    check("resume2_x0", int'(alien0_x), 294);

    // Restart coincident with frame_pulse while a move is pending
    idle_cyc(1, 1, 0, 0, 0);
    frame(4, -1, -1, 1, 0);
    frame(4, -1, -1, 1, 0);
    frame(4, 1, -1, 1, 0);
    check("restart_coinc_x0", int'(alien0_x), 290);
    check("restart_coinc_y", int'(alien_y), 40);

    // cfg_wr coincident with frame_pulse: old speed 0 still moves
    frame(4, -1, 1, 1, 2);
    check("cfg_coinc_x0", int'(alien0_x), 294);
    idle_cyc(1, 1, 0, 0, 0);

    // Run to landing
    guard = 0;
    while (m_land == 0 && guard < 6000) begin
      frame(3, -1, -1, 1, 0);
      guard++;
    end
    check("landing_reached", m_land, 1);
    idle_cyc(0, 1, 0, 0, 1);
    check("landed_flag", int'(landed), 1);
    check("landed_y", int'(alien_y), 360);
    x_save = int'(alien0_x);
    for (int f = 0; f < 5; f++) frame(4, -1, -1, 1, 0);
    check("landed_hold_x", int'(alien0_x), x_save);
    check("landed_hold_y", int'(alien_y), 360);
    idle_cyc(0, 1, 0, 1, 0);
    idle_cyc(0, 1, 0, 0, 1);
    check("restart_x0", int'(alien0_x), 290);
    check("restart_y", int'(alien_y), 40);
    check("restart_landed", int'(landed), 0);

    // Asynchronous reset mid-frame
    for (int f = 0; f < 3; f++) frame(5, -1, -1, 1, 0);
    @(negedge vga_clk);
    #2;
    wb_rst_i = 1'b1;
    #1;
    check("midreset_x0", int'(alien0_x), 290);
    check("midreset_y", int'(alien_y), 40);
    check("midreset_dir", int'(dir), 1);
    check("midreset_move_pulse", int'(move_pulse), 0);
    model_reset();
    sb_q.delete();
    idle_cyc(1, 1, 1, 0, 0);
    idle_cyc(0, 1, 1, 0, 1);

    // Randomized frames with sporadic restarts and config writes
    for (int f = 0; f < 200; f++) begin
      len   = $urandom_range(3, 8);
      rs_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, len - 1)) : -1;
      cw_at = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, len - 1)) : -1;
      ce    = ($urandom_range(0, 3) != 0) ? 1 : 0;
      cs    = $urandom_range(0, 3);
      frame(len, rs_at, cw_at, ce, cs);
    end

    for (int i = 0; i < 4; i++) idle_cyc(0, 0, 0, 0, (i == 3) ? 1 : 0);
    check("scoreboard_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
